// File: rtl/aes_cypher_fsm_if.sv
// Tile-side signal bundle for the byte-serial AES-128 core.
// The bench drives through master; the core sits on slave.
interface aes_cypher_fsm_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [2:0] fsm_state;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe, fsm_state
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe, fsm_state
    );
endinterface

// File: rtl/aes_cypher_fsm.sv
// Byte-serial AES-128 encryption core behind a TinyTapeout-style tile interface.
// One shared S-box serves SubBytes and the on-the-fly key schedule.
module aes_cypher_fsm (
    input  logic            clk,
    input  logic            rst,
    aes_cypher_fsm_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARK0      = 3'd1,
        S_SUB       = 3'd2,
        S_SHIFT_MIX = 3'd3,
        S_ARK       = 3'd4,
        S_DONE      = 3'd5
    } fsm_t;

    fsm_t state, state_next;

    // Strobe protocol: every uio_in control bit is a level sampled on each rising
    // clk edge with ena=1; a byte write is taken whenever its strobe is high and
    // busy=0, start is taken only when busy=0 and then drops any same-cycle write,
    // and rd steps the readout pointer once per sampled cycle while done=1.
    logic wr_key, wr_data, start, rd, disp_sel;
    logic unused_uio;
    assign wr_key     = bus.uio_in[0];
    assign wr_data    = bus.uio_in[1];
    assign start      = bus.uio_in[2];
    assign rd         = bus.uio_in[3];
    assign disp_sel   = bus.uio_in[4];
    assign unused_uio = ^bus.uio_in[7:5];

    logic [7:0] key [16];
    logic [7:0] st  [16];
    logic [7:0] wk  [16];
    logic [7:0] tmp [4];
    logic [3:0] kptr, dptr, rd_ptr, rnd;
    logic [4:0] cnt;
    logic       busy, done, go;

    assign busy = (state == S_ARK0) || (state == S_SUB) ||
                  (state == S_SHIFT_MIX) || (state == S_ARK);
    assign done = (state == S_DONE);
    assign go   = bus.ena && start && !busy;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (product of b^2..b^128), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0:    return 7'h3F;
            4'h1:    return 7'h06;
            4'h2:    return 7'h5B;
            4'h3:    return 7'h4F;
            4'h4:    return 7'h66;
            4'h5:    return 7'h6D;
            4'h6:    return 7'h7D;
            4'h7:    return 7'h07;
            4'h8:    return 7'h7F;
            4'h9:    return 7'h6F;
            4'hA:    return 7'h77;
            default: return 7'h40;
        endcase
    endfunction

    // SUB steps 0..15 substitute the state; steps 16..19 feed RotWord(w3) to the S-box.
    logic [1:0] kj;
    logic [7:0] sbox_in, sbox_out;
    always_comb begin
        kj = cnt[1:0] + 2'd1;
        if (!cnt[4]) sbox_in = st[cnt[3:0]];
        else         sbox_in = wk[{2'b11, kj}];
        sbox_out = sbox(sbox_in);
    end

    logic [7:0] sr [16];
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = st[4*((c + r) % 4) + r];
            end
        end
    end

    logic [7:0] mc [16];
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            if (rnd == 4'd10) begin
                for (int r = 0; r < 4; r++) mc[4*c + r] = sr[4*c + r];
            end else begin
                mc[4*c]     = xtime(sr[4*c])   ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
                mc[4*c + 1] = xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3] ^ sr[4*c];
                mc[4*c + 2] = xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3] ^ sr[4*c]   ^ sr[4*c+1];
                mc[4*c + 3] = xtime(sr[4*c+3]) ^ xtime(sr[4*c])   ^ sr[4*c]   ^ sr[4*c+1] ^ sr[4*c+2];
            end
        end
    end

    // Next round key: each row is a running XOR down the columns, seeded by the g() word.
    logic [7:0] nk [16];
    logic [7:0] nk_acc;
    always_comb begin
        nk_acc = 8'h00;
        for (int r = 0; r < 4; r++) begin
            nk_acc = wk[r] ^ tmp[r] ^ ((r == 0) ? rcon(rnd) : 8'h00);
            nk[r]  = nk_acc;
            for (int c = 1; c < 4; c++) begin
                nk_acc       = nk_acc ^ wk[4*c + r];
                nk[4*c + r]  = nk_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)           state <= S_IDLE;
        else if (bus.ena)  state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (start) state_next = S_ARK0;
            S_ARK0:      state_next = S_SUB;
            S_SUB:       if (cnt == 5'd19) state_next = S_SHIFT_MIX;
            S_SHIFT_MIX: state_next = S_ARK;
            S_ARK:       state_next = (rnd == 4'd10) ? S_DONE : S_SUB;
            S_DONE: begin
                if (start)        state_next = S_ARK0;
                else if (wr_data) state_next = S_IDLE;
            end
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                key[i] <= 8'h00;
                st[i]  <= 8'h00;
                wk[i]  <= 8'h00;
            end
            for (int i = 0; i < 4; i++) tmp[i] <= 8'h00;
            kptr   <= 4'd0;
            dptr   <= 4'd0;
            rd_ptr <= 4'd0;
            rnd    <= 4'd0;
            cnt    <= 5'd0;
        end else if (bus.ena) begin
            if (go) begin
                kptr   <= 4'd0;
                dptr   <= 4'd0;
                rd_ptr <= 4'd0;
                rnd    <= 4'd0;
                cnt    <= 5'd0;
                for (int i = 0; i < 16; i++) wk[i] <= key[i];
            end else if (!busy) begin
                if (wr_key) begin
                    key[kptr] <= bus.ui_in;
                    kptr      <= kptr + 4'd1;
                end
                if (wr_data) begin
                    st[dptr] <= bus.ui_in;
                    dptr     <= dptr + 4'd1;
                end
                if (rd && done) rd_ptr <= rd_ptr + 4'd1;
            end
            case (state)
                S_ARK0: begin
                    for (int i = 0; i < 16; i++) st[i] <= st[i] ^ wk[i];
                    rnd <= 4'd1;
                    cnt <= 5'd0;
                end
                S_SUB: begin
                    if (!cnt[4]) st[cnt[3:0]] <= sbox_out;
                    else         tmp[cnt[1:0]] <= sbox_out;
                    cnt <= cnt + 5'd1;
                end
                S_SHIFT_MIX: begin
                    for (int i = 0; i < 16; i++) begin
                        st[i] <= mc[i];
                        wk[i] <= nk[i];
                    end
                end
                S_ARK: begin
                    for (int i = 0; i < 16; i++) st[i] <= st[i] ^ wk[i];
                    cnt <= 5'd0;
                    if (rnd != 4'd10) rnd <= rnd + 4'd1;
                end
                default: ;
            endcase
        end
    end

    logic [6:0] seg;
    always_comb begin
        if (state == S_IDLE) seg = 7'h40;
        else if (done)       seg = 7'h5E;
        else                 seg = seg7(rnd);
        if (disp_sel)  bus.uo_out = {done, seg};
        else if (done) bus.uo_out = st[rd_ptr];
        else           bus.uo_out = 8'h00;
        bus.uio_out   = {1'b0, done, busy, 5'b00000};
        bus.uio_oe    = 8'hE0;
        bus.fsm_state = state;
    end
endmodule

// File: tb/tb_aes_cypher_fsm.sv
// Bench for aes_cypher_fsm: FIPS-197 vectors, display, abort, freeze and random
// key/plaintext runs scored against a word-level AES-128 reference model.
module tb_aes_cypher_fsm;
    logic clk = 1'b0;
    logic rst;
    aes_cypher_fsm_if bus ();

    aes_cypher_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] seen_q [$];
    logic [7:0] sb [256];
    logic [7:0] m_key [16];
    logic [7:0] m_pt [16];
    logic       disp;
    int         base_cyc, cyc;
    logic [7:0] dig [11] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                             8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h77};

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        int p, x, y;
        p = 0;
        x = int'(a);
        y = int'(b);
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 283;
            y = y >> 1;
        end
        return p[7:0];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            end
            sb[x] = s;
        end
    endtask

    task automatic model_encrypt();
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        logic [7:0]  s  [4][4];
        logic [7:0]  sh [4][4];
        logic [7:0]  a  [4];
        for (int i = 0; i < 4; i++) w[i] = {m_key[4*i], m_key[4*i+1], m_key[4*i+2], m_key[4*i+3]};
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[23:0], t[31:24]};
                t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h000000};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = m_pt[r + 4*c] ^ 8'(w[c] >> (24 - 8*r));
        for (int round = 1; round <= 10; round++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    sh[r][c] = sb[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = sh[r][c];
                for (int r = 0; r < 4; r++) begin
                    if (round < 10)
                        s[r][c] = gm(a[r], 8'h02) ^ gm(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                    else
                        s[r][c] = a[r];
                    s[r][c] = s[r][c] ^ 8'(w[4*round + c] >> (24 - 8*r));
                end
            end
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(s[i % 4][i / 4]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] ops, input logic [7:0] data);
        bus.ui_in  = data;
        bus.uio_in = {3'b000, disp, ops};
        @(negedge clk);
        bus.uio_in = {3'b000, disp, 4'b0000};
    endtask

    task automatic set_disp(input logic d);
        disp       = d;
        bus.uio_in = {3'b000, d, 4'b0000};
        #1;
    endtask

    task automatic set_vec(input logic [127:0] k, input logic [127:0] p);
        for (int i = 0; i < 16; i++) begin
            m_key[i] = k[127 - 8*i -: 8];
            m_pt[i]  = p[127 - 8*i -: 8];
        end
    endtask

    task automatic push_const(input logic [127:0] v);
        for (int i = 0; i < 16; i++) exp_q.push_back(v[127 - 8*i -: 8]);
    endtask

    task automatic load_key();
        for (int i = 0; i < 16; i++) drive(4'b0001, m_key[i]);
    endtask

    task automatic load_pt();
        for (int i = 0; i < 16; i++) drive(4'b0010, m_pt[i]);
    endtask

    task automatic start_enc();
        drive(4'b0100, 8'h00);
    endtask

    // Counts cycles until done; optionally drops ena for 50 cycles from freeze_at.
    task automatic wait_done(input int freeze_at, output int n);
        n = 0;
        seen_q.delete();
        while (bus.uio_out[6] !== 1'b1 && n < 600) begin
            if (disp && bus.uio_out[5] === 1'b1) begin
                if (seen_q.size() == 0 || seen_q[$] != bus.uo_out) seen_q.push_back(bus.uo_out);
            end
            if (n == freeze_at)      bus.ena = 1'b0;
            if (n == freeze_at + 50) bus.ena = 1'b1;
            @(negedge clk);
            n++;
        end
        bus.ena = 1'b1;
        check_val("done_seen", 32'(bus.uio_out[6]), 32'd1);
        check_val("busy_clear", 32'(bus.uio_out[5]), 32'd0);
    endtask

    task automatic read_check(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 16; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check_val(tag, 32'(bus.uo_out), 32'(e));
            drive(4'b1000, 8'h00);
        end
    endtask

    task automatic run_and_check(input string tag, input logic use_model);
        load_key();
        load_pt();
        start_enc();
        wait_done(-1, cyc);
        if (use_model) model_encrypt();
        read_check(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_sbox();
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        disp       = 1'b0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check_val("rst_uo", 32'(bus.uo_out), 32'h00);
        check_val("rst_uio", 32'(bus.uio_out), 32'h00);
        check_val("uio_oe", 32'(bus.uio_oe), 32'hE0);
        set_disp(1'b1);
        check_val("rst_disp", 32'(bus.uo_out), 32'h40);

        // Vector 1 with the display selected while busy.
        set_vec(K1, P1);
        load_key();
        load_pt();
        start_enc();
        wait_done(-1, base_cyc);
        check_val("latency_le_256", 32'(base_cyc <= 256), 32'd1);
        check_val("disp_done", 32'(bus.uo_out), 32'hDE);
        check_val("digit_count", 32'(seen_q.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            check_val("digit", 32'((i < seen_q.size()) ? seen_q[i] : 8'hxx), 32'(dig[i]));
        end
        set_disp(1'b0);
        push_const(C1);
        read_check("t1_ct");

        // Vector 2 plus readout wrap.
        set_vec(K2, P2);
        push_const(C2);
        run_and_check("t2_ct", 1'b0);
        check_val("t2_wrap", 32'(bus.uo_out), 32'h39);

        // Stray start/write strobes while busy are ignored.
        set_vec(K1, P1);
        load_key();
        load_pt();
        start_enc();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) drive(4'($urandom_range(1, 7)), 8'($urandom));
            else @(negedge clk);
        end
        wait_done(-1, cyc);
        push_const(C1);
        read_check("t4_ct");

        // Reset mid-encryption aborts, then a full reload works.
        load_key();
        load_pt();
        start_enc();
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_uio", 32'(bus.uio_out), 32'h00);
        check_val("abort_uo", 32'(bus.uo_out), 32'h00);
        push_const(C1);
        run_and_check("t5_ct", 1'b0);

        // ena low for 50 cycles delays done by exactly 50.
        load_key();
        load_pt();
        start_enc();
        wait_done(60, cyc);
        check_val("freeze_delay", 32'(cyc), 32'(base_cyc + 50));
        push_const(C1);
        read_check("t6_ct");

        // Random vectors, then key reuse with ignored strobes while ena=0.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) begin
                m_key[i] = 8'($urandom);
                m_pt[i]  = 8'($urandom);
            end
            run_and_check("rnd_ct", 1'b1);

            for (int i = 0; i < 16; i++) m_pt[i] = 8'($urandom);
            load_pt();
            check_val("wr_clears_done", 32'(bus.uio_out[6]), 32'd0);
            bus.ena = 1'b0;
            for (int i = 0; i < 3; i++) drive(4'b0111, 8'($urandom));
            bus.ena = 1'b1;
            start_enc();
            wait_done(-1, cyc);
            model_encrypt();
            read_check("reuse_ct");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
